// File: rtl/maze_carve_ctrl_if.sv
// Start/dimension inputs, status outputs and wall-memory write port of the
// maze carving controller, bundled for connection between controller and host.
interface maze_carve_ctrl_if;
    logic       start;
    logic [2:0] x_dimension;
    logic [2:0] y_dimension;
    logic       busy;
    logic       finish;
    logic       wr_en;
    logic [5:0] wr_addr;
    logic [3:0] wr_data;
    logic [6:0] cells_carved;

    modport master (
        output start, x_dimension, y_dimension,
        input  busy, finish, wr_en, wr_addr, wr_data, cells_carved
    );

    modport slave (
        input  start, x_dimension, y_dimension,
        output busy, finish, wr_en, wr_addr, wr_data, cells_carved
    );
endinterface

// File: rtl/maze_carve_ctrl.sv
// Randomized depth-first maze carver: sweeps a 64-cell wall memory to all-walls,
// then knocks down walls along an LFSR-guided DFS over a W x H sub-grid.
module maze_carve_ctrl #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst_n,
    maze_carve_ctrl_if.slave mc
);
    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_VISIT0, S_PICK, S_CARVE_A, S_CARVE_B, S_POP, S_DONE
    } state_e;

    localparam logic [3:0] ALL_WALLS = 4'b1111;

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [2:0]  xdim_q, xdim_d;
    logic [2:0]  ydim_q, ydim_d;
    logic [63:0] visited_q, visited_d;
    logic [6:0]  sp_q, sp_d;
    logic [5:0]  cur_q, cur_d;
    logic [5:0]  nbr_q, nbr_d;
    logic [1:0]  dir_q, dir_d;
    logic [6:0]  cells_q, cells_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic        busy_q, busy_d;
    logic        finish_q, finish_d;
    logic        wr_en_q, wr_en_d;
    logic [5:0]  wr_addr_q, wr_addr_d;
    logic [3:0]  wr_data_q, wr_data_d;

    logic [3:0]  shadow_q [64];
    logic [5:0]  stack_q  [64];
    logic        stack_we_s;
    logic [5:0]  stack_waddr_s;
    logic [5:0]  stack_wdata_s;
    logic [6:0]  sp_dec_s;
    logic [3:0]  mask_s;
    logic [1:0]  pick_dir_s;
    logic [1:0]  cand_s;
    logic        pick_found_s;

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    function automatic logic [5:0] nbr_index(input logic [5:0] c, input logic [1:0] d);
        logic [5:0] n;
        case (d)
            2'd0:    n = c - 6'd8;
            2'd1:    n = c + 6'd1;
            2'd2:    n = c + 6'd8;
            2'd3:    n = c - 6'd1;
            default: n = c;
        endcase
        return n;
    endfunction

    // Edge tests come first so an off-grid index never reaches the visited lookup.
    function automatic logic [3:0] nbr_mask(input logic [5:0] c, input logic [63:0] vis,
                                            input logic [2:0] xd, input logic [2:0] yd);
        logic [3:0] m;
        m    = 4'b0000;
        m[0] = (c[5:3] != 3'd0) && !vis[c - 6'd8];
        m[1] = (c[2:0] <  xd)   && !vis[c + 6'd1];
        m[2] = (c[5:3] <  yd)   && !vis[c + 6'd8];
        m[3] = (c[2:0] != 3'd0) && !vis[c - 6'd1];
        return m;
    endfunction

    function automatic logic [3:0] clear_wall(input logic [3:0] w, input logic [1:0] d);
        return w & ~(4'b0001 << d);
    endfunction

    // Direction choice: first open neighbour scanning round-robin from lfsr[1:0].
    always_comb begin
        mask_s       = nbr_mask(cur_q, visited_q, xdim_q, ydim_q);
        pick_dir_s   = lfsr_q[1:0];
        pick_found_s = 1'b0;
        cand_s       = 2'd0;
        for (int k = 0; k < 4; k++) begin
            cand_s = lfsr_q[1:0] + 2'(k);
            if (!pick_found_s && mask_s[cand_s]) begin
                pick_dir_s   = cand_s;
                pick_found_s = 1'b1;
            end else begin
                pick_found_s = pick_found_s;
            end
        end
    end

    // Next-state logic; output registers are loaded with the values of the state being entered.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        xdim_d        = xdim_q;
        ydim_d        = ydim_q;
        visited_d     = visited_q;
        sp_d          = sp_q;
        cur_d         = cur_q;
        nbr_d         = nbr_q;
        dir_d         = dir_q;
        cells_d       = cells_q;
        lfsr_d        = lfsr_next(lfsr_q);
        wr_en_d       = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        stack_we_s    = 1'b0;
        stack_waddr_s = sp_q[5:0];
        stack_wdata_s = nbr_q;
        sp_dec_s      = sp_q - 7'd1;

        case (state_q)
            S_IDLE: begin
                if (mc.start) begin
                    state_d   = S_INIT;
                    xdim_d    = mc.x_dimension;
                    ydim_d    = mc.y_dimension;
                    cnt_d     = 6'd0;
                    cells_d   = 7'd0;
                    wr_en_d   = 1'b1;
                    wr_addr_d = 6'd0;
                    wr_data_d = ALL_WALLS;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_INIT: begin
                visited_d = 64'd0;
                sp_d      = 7'd0;
                if (cnt_q == 6'd63) begin
                    state_d = S_VISIT0;
                end else begin
                    cnt_d     = cnt_q + 6'd1;
                    wr_en_d   = 1'b1;
                    wr_addr_d = cnt_q + 6'd1;
                    wr_data_d = ALL_WALLS;
                end
            end
            S_VISIT0: begin
                visited_d[0]  = 1'b1;
                stack_we_s    = 1'b1;
                stack_waddr_s = 6'd0;
                stack_wdata_s = 6'd0;
                sp_d          = 7'd1;
                cur_d         = 6'd0;
                cells_d       = 7'd1;
                state_d       = S_PICK;
            end
            S_PICK: begin
                if (mask_s != 4'b0000) begin
                    dir_d     = pick_dir_s;
                    nbr_d     = nbr_index(cur_q, pick_dir_s);
                    wr_en_d   = 1'b1;
                    wr_addr_d = cur_q;
                    wr_data_d = clear_wall(shadow_q[cur_q], pick_dir_s);
                    state_d   = S_CARVE_A;
                end else begin
                    state_d = S_POP;
                end
            end
            S_CARVE_A: begin
                wr_en_d   = 1'b1;
                wr_addr_d = nbr_q;
                wr_data_d = clear_wall(shadow_q[nbr_q], dir_q + 2'd2);
                state_d   = S_CARVE_B;
            end
            S_CARVE_B: begin
                visited_d[nbr_q] = 1'b1;
                stack_we_s       = 1'b1;
                sp_d             = sp_q + 7'd1;
                cur_d            = nbr_q;
                cells_d          = cells_q + 7'd1;
                state_d          = S_PICK;
            end
            S_POP: begin
                sp_d = sp_dec_s;
                if (sp_dec_s == 7'd0) begin
                    state_d = S_DONE;
                end else begin
                    cur_d   = stack_q[sp_dec_s[5:0] - 6'd1];
                    state_d = S_PICK;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d   = (state_d != S_IDLE);
        finish_d = (state_d == S_DONE);
    end

    // Control state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= 6'd0;
            xdim_q    <= 3'd0;
            ydim_q    <= 3'd0;
            visited_q <= 64'd0;
            sp_q      <= 7'd0;
            cur_q     <= 6'd0;
            nbr_q     <= 6'd0;
            dir_q     <= 2'd0;
            cells_q   <= 7'd0;
            lfsr_q    <= SEED;
            busy_q    <= 1'b0;
            finish_q  <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= 6'd0;
            wr_data_q <= 4'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            xdim_q    <= xdim_d;
            ydim_q    <= ydim_d;
            visited_q <= visited_d;
            sp_q      <= sp_d;
            cur_q     <= cur_d;
            nbr_q     <= nbr_d;
            dir_q     <= dir_d;
            cells_q   <= cells_d;
            lfsr_q    <= lfsr_d;
            busy_q    <= busy_d;
            finish_q  <= finish_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Wall shadow mirrors every external write; the DFS stack holds visited cell indices.
    always_ff @(posedge clk) begin
        if (wr_en_d) begin
            shadow_q[wr_addr_d] <= wr_data_d;
        end
        if (stack_we_s) begin
            stack_q[stack_waddr_s] <= stack_wdata_s;
        end
    end

    assign mc.busy         = busy_q;
    assign mc.finish       = finish_q;
    assign mc.wr_en        = wr_en_q;
    assign mc.wr_addr      = wr_addr_q;
    assign mc.wr_data      = wr_data_q;
    assign mc.cells_carved = cells_q;
endmodule

// File: tb/tb_maze_carve_ctrl.sv
// Self-checking bench for maze_carve_ctrl: table of grid runs plus random runs,
// each compared against a cycle-timed DFS reference and a spanning-tree analysis.
module tb_maze_carve_ctrl;
    localparam logic [15:0] TB_SEED = 16'hACE1;

    typedef struct {
        int cyc;
        int addr;
        int data;
    } wr_t;

    typedef struct {
        logic [2:0] xd;
        logic [2:0] yd;
        int         wait_cyc;
        bit         poke;
        int         exp_cells;
        int         exp_carves;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] m_lfsr;
    int          n_cmp = 0;
    int          n_mis = 0;
    wr_t         exp_q [$];
    wr_t         last_dq [$];
    int          last_fin;
    vec_t        vecs [8];

    maze_carve_ctrl_if mc ();

    maze_carve_ctrl #(.SEED(TB_SEED)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mc    (mc)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    // Reference LFSR: value visible during each clock cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= TB_SEED;
        else        m_lfsr <= lfsr_step(m_lfsr);
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},   int'(mc.busy),         0);
        check({tag, "_finish"}, int'(mc.finish),       0);
        check({tag, "_wr_en"},  int'(mc.wr_en),        0);
        check({tag, "_addr"},   int'(mc.wr_addr),      0);
        check({tag, "_data"},   int'(mc.wr_data),      0);
        check({tag, "_cells"},  int'(mc.cells_carved), 0);
    endtask

    // DFS over the grid with cycle numbers relative to the start-sampling cycle 0:
    // INIT 1..64, VISIT0 65, first PICK 66; carve = PICK,A,B; dead end = PICK,POP.
    task automatic build_model(input logic [2:0] xd, input logic [2:0] yd, input logic [15:0] l0,
                               output int fin, output int cells);
        logic [15:0] seq [1024];
        logic [3:0]  walls [64];
        bit          vis [64];
        bit          avail [4];
        int          stk [$];
        int          dlt [4];
        int          t, cur, cx, cy, d, nb, r;
        dlt[0] = -8; dlt[1] = 1; dlt[2] = 8; dlt[3] = -1;
        seq[0] = l0;
        for (int i = 1; i < 1024; i++) seq[i] = lfsr_step(seq[i-1]);
        for (int i = 0; i < 64; i++) begin walls[i] = 4'hF; vis[i] = 1'b0; end
        exp_q.delete();
        vis[0] = 1'b1; stk.push_back(0); cells = 1; t = 66; fin = -1;
        while (fin < 0 && t < 1000) begin
            cur = stk[$]; cx = cur % 8; cy = cur / 8;
            avail[0] = (cy > 0)        && !vis[cur-8];
            avail[1] = (cx < int'(xd)) && !vis[cur+1];
            avail[2] = (cy < int'(yd)) && !vis[cur+8];
            avail[3] = (cx > 0)        && !vis[cur-1];
            if (avail[0] || avail[1] || avail[2] || avail[3]) begin
                r = int'(seq[t][1:0]);
                d = -1;
                for (int k = 0; k < 4; k++) if (d < 0 && avail[(r+k)%4]) d = (r+k) % 4;
                nb = cur + dlt[d];
                walls[cur][d] = 1'b0;
                exp_q.push_back('{t+1, cur, int'(walls[cur])});
                walls[nb][(d+2)%4] = 1'b0;
                exp_q.push_back('{t+2, nb, int'(walls[nb])});
                vis[nb] = 1'b1; stk.push_back(nb); cells++; t += 3;
            end else begin
                void'(stk.pop_back());
                if (stk.size() == 0) fin = t + 2;
                else                 t += 2;
            end
        end
    endtask

    task automatic run_grid(input logic [2:0] xd, input logic [2:0] yd, input int wait_cyc,
                            input bit poke, input int exp_cells, input int exp_carves);
        int         fin, mcells, cells_obs, init_bad, first_fin, fin_cnt, busy_bad;
        int         oog, dup, bad_walls, pass, reach, c, x, y;
        logic [3:0] wm [64];
        bit         seen [64];
        int         bfs [$];
        wr_t        dq [$];
        init_bad = -1; first_fin = -1; fin_cnt = 0; busy_bad = -1; cells_obs = -1;
        repeat (wait_cyc) @(negedge clk);
        @(negedge clk);
        build_model(xd, yd, m_lfsr, fin, mcells);
        mc.start = 1'b1; mc.x_dimension = xd; mc.y_dimension = yd;
        for (int n = 1; n <= fin + 3; n++) begin
            @(negedge clk);
            if (n <= 64) begin
                if (init_bad < 0 && !(mc.wr_en && mc.wr_addr == 6'(n - 1) && mc.wr_data == 4'hF))
                    init_bad = n;
            end else if (mc.wr_en) begin
                dq.push_back('{n, int'(mc.wr_addr), int'(mc.wr_data)});
            end
            if (mc.finish) begin
                fin_cnt++;
                if (first_fin < 0) first_fin = n;
            end
            if (busy_bad < 0 && mc.busy != (n <= fin)) busy_bad = n;
            if (n == fin + 1) cells_obs = int'(mc.cells_carved);
            // start while busy (and dimension changes) must have no effect
            mc.start = poke && (n == 20 || n == fin - 1);
            if (n == 1 || mc.start) begin
                mc.x_dimension = 3'($urandom);
                mc.y_dimension = 3'($urandom);
            end
        end
        mc.start = 1'b0;
        if (mc.busy) begin
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
        end

        check("init_sweep_first_bad_cycle", init_bad, -1);
        check("finish_cycle", first_fin, fin);
        check("finish_pulse_count", fin_cnt, 1);
        check("busy_first_bad_cycle", busy_bad, -1);
        check("cells_vs_model", cells_obs, mcells);
        check("cells_vs_table", cells_obs, exp_cells);
        check("carve_count_vs_table", dq.size(), exp_carves);
        check("carve_count_vs_model", dq.size(), exp_q.size());
        for (int i = 0; i < dq.size() && i < exp_q.size(); i++)
            check($sformatf("carve_write_%0d_cyc1024_addr16_data", i),
                  dq[i].cyc * 1024 + dq[i].addr * 16 + dq[i].data,
                  exp_q[i].cyc * 1024 + exp_q[i].addr * 16 + exp_q[i].data);

        // Rebuild the maze from observed writes and judge it on its own.
        for (int i = 0; i < 64; i++) begin wm[i] = 4'hF; seen[i] = 1'b0; end
        oog = 0; dup = 0;
        for (int i = 0; i < dq.size(); i++) begin
            wm[dq[i].addr] = 4'(dq[i].data);
            if ((dq[i].addr % 8) > int'(xd) || (dq[i].addr / 8) > int'(yd)) oog++;
            for (int j = 0; j < i; j++)
                if (dq[j].addr == dq[i].addr && dq[j].data == dq[i].data) dup++;
        end
        bad_walls = 0; pass = 0;
        for (int yy = 0; yy <= int'(yd); yy++) begin
            for (int xx = 0; xx <= int'(xd); xx++) begin
                c = yy * 8 + xx;
                if (xx < int'(xd)) begin
                    if (wm[c][1] != wm[c+1][3]) bad_walls++;
                    else if (!wm[c][1])         pass++;
                end else if (!wm[c][1]) bad_walls++;
                if (yy < int'(yd)) begin
                    if (wm[c][2] != wm[c+8][0]) bad_walls++;
                    else if (!wm[c][2])         pass++;
                end else if (!wm[c][2]) bad_walls++;
                if (xx == 0 && !wm[c][3]) bad_walls++;
                if (yy == 0 && !wm[c][0]) bad_walls++;
            end
        end
        reach = 0; seen[0] = 1'b1; bfs.push_back(0);
        while (bfs.size() > 0) begin
            c = bfs.pop_front(); reach++; x = c % 8; y = c / 8;
            if (y > 0 && !wm[c][0] && !seen[c-8]) begin seen[c-8] = 1'b1; bfs.push_back(c-8); end
            if (x < int'(xd) && !wm[c][1] && !wm[c+1][3] && !seen[c+1]) begin seen[c+1] = 1'b1; bfs.push_back(c+1); end
            if (y < int'(yd) && !wm[c][2] && !wm[c+8][0] && !seen[c+8]) begin seen[c+8] = 1'b1; bfs.push_back(c+8); end
            if (x > 0 && !wm[c][3] && !wm[c-1][1] && !seen[c-1]) begin seen[c-1] = 1'b1; bfs.push_back(c-1); end
        end
        check("out_of_grid_writes", oog, 0);
        check("duplicate_identical_writes", dup, 0);
        check("inconsistent_walls", bad_walls, 0);
        check("passages", pass, exp_cells - 1);
        check("reachable_cells", reach, exp_cells);
        last_dq  = dq;
        last_fin = first_fin;
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen_carve;
        logic [2:0] rx, ry;
        vecs[0] = '{3'd0, 3'd0,  0, 1'b0,  1,   0};
        vecs[1] = '{3'd1, 3'd0,  2, 1'b0,  2,   2};
        vecs[2] = '{3'd2, 3'd4,  5, 1'b0, 15,  28};
        vecs[3] = '{3'd7, 3'd7,  1, 1'b0, 64, 126};
        vecs[4] = '{3'd7, 3'd7, 17, 1'b0, 64, 126};
        vecs[5] = '{3'd7, 3'd7, 40, 1'b1, 64, 126};
        vecs[6] = '{3'd0, 3'd7,  3, 1'b0,  8,  14};
        vecs[7] = '{3'd3, 3'd1,  9, 1'b1,  8,  14};

        mc.start = 1'b0; mc.x_dimension = 3'd0; mc.y_dimension = 3'd0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("in_reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("idle_after_reset");

        foreach (vecs[i])
            run_grid(vecs[i].xd, vecs[i].yd, vecs[i].wait_cyc, vecs[i].poke,
                     vecs[i].exp_cells, vecs[i].exp_carves);

        // 1x1: finish exactly at cycle 68
        run_grid(3'd0, 3'd0, 4, 1'b0, 1, 0);
        check("finish_cycle_1x1", last_fin, 68);

        // 2x1: two fixed carve writes
        run_grid(3'd1, 3'd0, 7, 1'b1, 2, 2);
        check("2x1_first_addr",  last_dq.size() > 0 ? last_dq[0].addr : -1, 0);
        check("2x1_first_data",  last_dq.size() > 0 ? last_dq[0].data : -1, 13);
        check("2x1_second_addr", last_dq.size() > 1 ? last_dq[1].addr : -1, 1);
        check("2x1_second_data", last_dq.size() > 1 ? last_dq[1].data : -1, 7);

        for (int r = 0; r < 4; r++) begin
            rx = 3'($urandom_range(0, 7));
            ry = 3'($urandom_range(0, 7));
            run_grid(rx, ry, int'($urandom_range(0, 30)), 1'($urandom),
                     (int'(rx) + 1) * (int'(ry) + 1), 2 * ((int'(rx) + 1) * (int'(ry) + 1) - 1));
        end

        // reset in the middle of carving, then a fresh run must redo INIT from address 0
        @(negedge clk);
        mc.start = 1'b1; mc.x_dimension = 3'd7; mc.y_dimension = 3'd7;
        @(negedge clk);
        mc.start = 1'b0;
        seen_carve = 0;
        for (int n = 2; n < 400 && seen_carve == 0; n++) begin
            @(negedge clk);
            if (n > 66 && mc.wr_en) seen_carve = 1;
        end
        check("carve_reached_before_reset", seen_carve, 1);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_carve_reset");
        @(negedge clk);
        rst_n = 1'b1;
        run_grid(3'd7, 3'd7, 3, 1'b0, 64, 126);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/maze_carve_ctrl.md
MAZE_CARVE_CTRL -- requirements
Module: maze_carve_ctrl

Interface
REQ-001 SHALL have parameter SEED, default 16'hACE1, the LFSR reset value; it must be nonzero.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: begin a carve run when sampled high in IDLE.
REQ-005 SHALL have port x_dimension, input, 3 bits: grid width minus 1 (W = x_dimension+1, range 1..8).
REQ-006 SHALL have port y_dimension, input, 3 bits: grid height minus 1 (H = y_dimension+1, range 1..8).
REQ-007 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-008 SHALL have port finish, output, 1 bit: one-cycle pulse when the run completes.
REQ-009 SHALL have port wr_en, output, 1 bit: wall-memory write strobe.
REQ-010 SHALL have port wr_addr, output, 6 bits: cell index = y*8 + x, fixed stride 8.
REQ-011 SHALL have port wr_data, output, 4 bits: walls {W,S,E,N} = bits [3:0]; 1 = wall present.
REQ-012 SHALL have port cells_carved, output, 7 bits: number of cells visited in the current or last run.

Function
REQ-013 SHALL run a randomized depth-first carve on a W x H grid, starting at cell (0,0).
REQ-014 SHALL latch x_dimension and y_dimension on start acceptance; later input changes have no effect until the next run.
REQ-015 SHALL ignore start while busy is high.
REQ-016 SHALL use the following states: IDLE, INIT, VISIT0, PICK, CARVE_A, CARVE_B, POP, DONE; each state lasts one cycle unless noted.
REQ-017 INIT SHALL last 64 cycles, writing 4'b1111 to addresses 0..63 in ascending order (wr_en=1 each cycle), and SHALL clear the internal 64-bit visited map and the stack.
REQ-018 VISIT0 SHALL mark (0,0) visited, push index 0, and set cells_carved=1.
REQ-019 PICK SHALL form the neighbour mask, bit d set if neighbour d is in-grid and unvisited; d: 0=N(y-1), 1=E(x+1), 2=S(y+1), 3=W(x-1).
REQ-020 PICK transitions:
- Mask nonzero: choose the first set bit scanning d = r, r+1, r+2, r+3 (mod 4), where r = lfsr[1:0]; go to CARVE_A.
- Mask zero: go to POP.
REQ-021 CARVE_A SHALL write the current cell with wall bit d cleared.
REQ-022 CARVE_B SHALL:
- write the neighbour with the opposite bit (d+2 mod 4) cleared;
- mark the neighbour visited, push it, make it current, and increment cells_carved;
- go to PICK.
REQ-023 The controller SHALL keep a 64x4 internal wall shadow so every write carries the full updated 4-bit value of that cell.
REQ-024 POP SHALL pop the stack:
- stack empty afterwards: go to DONE;
- otherwise: current = new top; go to PICK.
REQ-025 DONE SHALL assert finish for exactly one cycle, then return to IDLE.
REQ-026 wr_en SHALL be high only in INIT, CARVE_A, and CARVE_B.
REQ-027 The stack SHALL be 64 entries x 6 bits; it cannot overflow, since each cell is pushed at most once.
REQ-028 The LFSR SHALL be 16 bits, Fibonacci form, taps 16,14,13,11, and SHALL advance every cycle that rst_n is high, including IDLE.
REQ-029 Grid boundary: neighbours with x>x_dim, y>y_dim, x<0 or y<0 are never in the mask; cells outside the grid keep 4'b1111.

Reset
REQ-030 On rst_n low, the following SHALL apply immediately, regardless of state:
- state=IDLE, busy=0, finish=0, wr_en=0;
- wr_addr=0, wr_data=0, cells_carved=0;
- lfsr=SEED.
REQ-031 Reset mid-run SHALL abandon the run; the next start SHALL perform a full INIT.

Verification
REQ-032 1x1 grid: start (dims 0,0) accepted at cycle 0 -> INIT writes cycles 1-64, finish high at cycle 68 only, no carve writes, cells_carved=1.
REQ-033 2x1 grid (x_dim=1, y_dim=0) -> after INIT, exactly two carve writes: addr 0 data 4'b1101, then addr 1 data 4'b0111; cells_carved=2; finish pulses once.
REQ-034 8x8 grid with several seeds -> exactly 63 CARVE_A/CARVE_B pairs, cells_carved=64, no address written twice during carving with identical data, and the shadow walls form a spanning tree (all 64 cells reachable, 63 passages).
REQ-035 3x5 grid -> addresses with x>2 or y>4 never written after INIT; every carve write stays in-grid; cells_carved=15.
REQ-036 start pulsed while busy -> ignored, the run completes unchanged; rst_n low mid-CARVE -> all outputs at reset values in the same cycle, and a new start repeats INIT from address 0.
